// File: rtl/rf_exec_pkg.sv
// Shared definitions for the register-file execution controller: opcodes, FSM
// states and instruction field positions. Optional feature macro: SAT_ARITH_EN.
package rf_exec_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 7;
   localparam int RS2_MSB = 6;
   localparam int RS2_LSB = 4;
   localparam int IMM_MSB = 3;
   localparam int IMM_LSB = 0;

   // CMP only updates flags; every other opcode writes its destination.
   function automatic logic op_writes(input logic [2:0] op);
      return op != OP_CMP;
   endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational ALU for rf_exec_ctrl. Arithmetic is done one bit wider than the
// data so the top bit is carry/borrow. SAT_ARITH_EN clamps ADD/SUB/CMP overflow.
module alu_4bit
   import rf_exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Flag C only comes from the arithmetic ops; logic/move ops leave it clear.
   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
`ifdef SAT_ARITH_EN
            if (sum[DATA_W]) result = '1;
`endif
         end
         OP_SUB, OP_CMP: begin
            result = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
`ifdef SAT_ARITH_EN
            if (diff[DATA_W]) result = '0;
`endif
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LDI:  result = imm;
         OP_MOV:  result = a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Single-issue IDLE/EXEC/WB controller in front of the register file.
// Build with SAT_ARITH_EN defined for saturating ADD/SUB/CMP.
module rf_exec_ctrl
   import rf_exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic              flag_z,
   output logic              flag_c,
   output logic              done,
   output logic              busy
);

   state_t state_q;
   state_t state_d;

   logic [15:0]       instr_q;
   logic [DATA_W-1:0] result_q;
   logic [ADDR_W-1:0] waddr_q;
   logic              pend_z;
   logic              pend_c;
   logic              accept;

   logic [2:0]        op;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   assign op        = instr_q[OP_MSB:OP_LSB];
   assign rf_raddr1 = ADDR_W'(instr_q[RS1_MSB:RS1_LSB]);
   assign rf_raddr2 = ADDR_W'(instr_q[RS2_MSB:RS2_LSB]);
   assign rf_waddr  = waddr_q;
   assign rf_wdata  = result_q;

   alu_4bit #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (op),
      .a      (rf_rdata1),
      .b      (rf_rdata2),
      .imm    (DATA_W'(instr_q[IMM_MSB:IMM_LSB])),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Write enable is decoded from the state so reset kills a pending write at once.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      busy        = 1'b1;
      rf_we       = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            accept      = instr_valid;
            if (instr_valid) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB: begin
            rf_we   = op_writes(op);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Result and pending flags are captured at the end of EXEC; the visible
   // flags only take them on the write-back edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= '0;
         result_q <= '0;
         waddr_q  <= '0;
         pend_z   <= 1'b0;
         pend_c   <= 1'b0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (accept) instr_q <= instr;
         if (state_q == ST_EXEC) begin
            result_q <= alu_result;
            waddr_q  <= ADDR_W'(instr_q[RD_MSB:RD_LSB]);
            pend_z   <= (alu_result == '0);
            pend_c   <= alu_carry;
         end
         if (state_q == ST_WB) begin
            flag_z <= pend_z;
            flag_c <= pend_c;
         end
         done <= (state_q == ST_EXEC);
      end
   end

endmodule
